conv_filter_kxk_mc: RTL
=======================

// Module: conv_filter_kxk_mc
// PURPOSE
//  Parametrised KxK signed convolution MAC, successor to the fixed 3x3 filter.
//  - Each beat multiplies one KxK input window by one KxK filter and sums the products.
//  - Accumulates the per-channel sums over up to NUM_CH input channels into one output pixel.
//  - Three-stage pipeline with valid/ready handshake; sits between the window line-buffer and the output writer.
// PARAMETERS
//  DATA_W  8   signed two's-complement width of each input/filter element
//  K       3   kernel edge; window holds K*K elements
//  NUM_CH  4   max channels per output pixel (>=1); counter wraps here
//  OUT_W   22  accumulator/output width; default = 2*DATA_W+clog2(K*K*NUM_CH)
// PORTS
//  clk            in   1           rising-edge clock
//  rst            in   1           synchronous reset, active-high
//  ena            in   1           global enable; low freezes all state
//  in_valid       in   1           in_matrix/filter_matrix/in_last valid
//  in_ready       out  1           beat accepted when in_valid&in_ready
//  in_matrix      in   K*K*DATA_W  window; element (r,c) at [(K*K-1-(r*K+c))*DATA_W +: DATA_W]
//  filter_matrix  in   K*K*DATA_W  kernel, same packing
//  in_last        in   1           beat is the final channel of this pixel
//  out_valid      out  1           out_data holds a completed pixel
//  out_ready      in   1           downstream accepts when out_valid&out_ready
//  out_data       out  OUT_W       signed accumulated pixel
// BEHAVIOUR
//  - Reset (sync, when rst=1 at clk edge): all valid flags 0, out_valid 0, out_data 0,
//    accumulator 0, channel counter 0, stage regs 0. rst overrides ena.
//  - adv = ena & ~(out_valid & ~out_ready). in_ready = adv (combinational).
//    Entire pipeline advances only when adv=1; otherwise every register holds.
//  - S1 (edge N, beat accepted): K*K products p[i] = in[i]*flt[i], 2*DATA_W signed, registered with v1, last1.
//  - S2 (edge N+1): s = sum of p[i], sign-extended to OUT_W, registered with v2, last2.
//  - S3 (edge N+2): if v2: total = acc + s.
//    - If last2 or ch_cnt==NUM_CH-1: out_data<=total, out_valid<=1, acc<=0, ch_cnt<=0.
//    - Else acc<=total, ch_cnt<=ch_cnt+1.
//  - Latency: out_valid rises 3 cycles after acceptance of the closing beat (with adv held 1).
//  - Group end: whichever comes first, in_last or the NUM_CH-th beat; in_last on the first beat yields a 1-channel pixel.
//  - out_valid clears when out_ready=1 at an edge and no new result lands; a new result landing on the handshake edge
//    replaces it (out_valid stays 1). Back-to-back pixels are sustained at 1/cycle if out_ready=1.
//  - out_data and out_valid stay stable while out_valid&~out_ready (no drop, no overwrite).
//  - Arithmetic: full-precision signed; if OUT_W is set below default, wraps modulo 2^OUT_W (no saturation).
//  - in_valid=0 with adv=1: bubble propagates (v1/v2=0); acc and ch_cnt unchanged.
//  - Reset mid-group: partial accumulation and in-flight beats discarded; next accepted beat starts channel 0.
//  - ena=0 mid-group: state frozen; resumes exactly where it stopped when ena returns to 1.
// CONFIGURATION
//  CONV_RELU_EN defined: value written to out_data is max(total,0); negative pixels emit 0.
//    acc itself is never clamped; only the final output is.
//  CONV_RELU_EN undefined: out_data is raw signed total.
// TESTING
//  1 ch: in {1,2,1,2,1,1,1,1,2}, flt all 1, in_last=1 -> out_data=12, out_valid 3 cycles after accept.
//  2 ch: beat A as above (last=0), then in {2,2,1,1,1,1,1,2,2},
//    flt {2,1,1,2,2,2,1,1,2} last=1 -> single pixel 12+20=32.
//  Wrap: 4 beats all-ones in/flt, in_last=0 -> out_data=36 after 4th beat; 5th beat starts new group (acc=0).
//  Sign/ReLU: in all 8'hFF (-1), flt all 1, last=1 -> -9 (22'h3FFFF7) without CONV_RELU_EN; 0 with it.
//  Backpressure: out_ready=0 with pixel pending -> in_ready=0, out_data stable;
//    out_ready=1 -> pixel consumed, next pixel 1 cycle later.
//  Reset/enable: rst=1 after 2 beats of a 4-ch group -> out_valid=0;
//    next 1-ch beat gives its own sum (12), not 12+prior.
//    ena=0 for 5 cycles mid-pipe -> output identical, delayed 5.

Source files
------------

// File: rtl/conv_filter_kxk_mc.sv
// KxK signed convolution MAC accumulating over up to NUM_CH channels per output pixel.
// Build option: define CONV_RELU_EN to clamp negative output pixels to zero.
module conv_filter_kxk_mc #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int NUM_CH = 4,
  parameter int OUT_W  = 2*DATA_W + $clog2(K*K*NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [K*K*DATA_W-1:0]    in_matrix,
  input  logic [K*K*DATA_W-1:0]    filter_matrix,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data
);

  localparam int KK    = K*K;
  localparam int PW    = 2*DATA_W;
  localparam int CNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Sign-extend (or wrap, if OUT_W is narrower) a product into accumulator width.
  function automatic logic signed [OUT_W-1:0] to_acc(input logic signed [PW-1:0] p);
    logic signed [63:0] w;
    w = 64'(p);
    return w[OUT_W-1:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] out_map(input logic signed [OUT_W-1:0] total);
`ifdef CONV_RELU_EN
    return (total < 0) ? '0 : total;
`else
    return total;
`endif
  endfunction

  logic                    adv;
  logic signed [PW-1:0]    prod_c  [KK];
  logic signed [PW-1:0]    prod_p1 [KK];
  logic                    vld_p1, last_p1;
  logic signed [OUT_W-1:0] sum_c;
  logic signed [OUT_W-1:0] sum_p2;
  logic                    vld_p2, last_p2;
  logic signed [OUT_W-1:0] acc;
  logic signed [OUT_W-1:0] total;
  logic [CNT_W-1:0]        ch_cnt;
  logic                    close_grp;

  // A pending, unaccepted output pixel stalls the whole pipeline.
  assign adv      = ena & ~(out_valid & ~out_ready);
  assign in_ready = adv;

  always_comb begin
    for (int i = 0; i < KK; i++) begin
      prod_c[i] = PW'($signed(in_matrix[(KK-1-i)*DATA_W +: DATA_W])) *
                  PW'($signed(filter_matrix[(KK-1-i)*DATA_W +: DATA_W]));
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < KK; i++) begin
      sum_c = sum_c + to_acc(prod_p1[i]);
    end
  end

  assign total     = acc + sum_p2;
  assign close_grp = last_p2 | (ch_cnt == CNT_W'(NUM_CH-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      for (int i = 0; i < KK; i++) prod_p1[i] <= '0;
      vld_p2    <= 1'b0;
      last_p2   <= 1'b0;
      sum_p2    <= '0;
      acc       <= '0;
      ch_cnt    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      // stage 1: element-wise products
      vld_p1  <= in_valid;
      last_p1 <= in_last;
      prod_p1 <= prod_c;
      // stage 2: per-channel sum
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
      sum_p2  <= sum_c;
      // stage 3: channel accumulation; any held pixel was consumed on this edge
      out_valid <= 1'b0;
      if (vld_p2) begin
        if (close_grp) begin
          out_data  <= out_map(total);
          out_valid <= 1'b1;
          acc       <= '0;
          ch_cnt    <= '0;
        end else begin
          acc    <= total;
          ch_cnt <= ch_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
